// File: rtl/pc_fetch_unit.sv
// Program counter and instruction register stage of the multi-cycle MIPS core.
// Holds the word-indexed PC, captures the fetched instruction, selects the
// next PC (sequential, branch, jump, jump-register), commits it at the end of
// each instruction, counts retired instructions and raises a sticky halt when
// the next PC would fall outside instruction memory.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 135
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  state,
    input  logic [31:0] ReadInstruction,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_value,
    output logic [31:0] InstrAddr,
    output logic [31:0] instr_reg,
    output logic [31:0] pc_plus1,
    output logic        halted,
    output logic [31:0] retired_count
);

    // One-hot control state encodings driven by the main controller.
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_FETCH     = 6'b000010,
        ST_DECODE    = 6'b000100,
        ST_EXECUTE   = 6'b001000,
        ST_MEM       = 6'b010000,
        ST_WRITEBACK = 6'b100000
    } ctrl_state_t;

    localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 1);

    logic [31:0] next_pc;
    logic [31:0] branch_offset;
    logic        next_in_range;
    logic        is_fetch;
    logic        is_writeback;

    // Decode the two states that matter here; anything else (including
    // non-one-hot values) matches neither and therefore changes nothing.
    always_comb begin
        is_fetch     = (state == ST_FETCH);
        is_writeback = (state == ST_WRITEBACK);
    end

    // Next-PC selection with jump-register over jump over taken branch over sequential.
    always_comb begin
        pc_plus1      = InstrAddr + 32'd1;
        branch_offset = {{16{instr_reg[15]}}, instr_reg[15:0]};
        next_pc       = pc_plus1;
        if (jump_reg) begin
            next_pc = rs_value;
        end else if (jump) begin
            next_pc = {pc_plus1[31:26], instr_reg[25:0]};
        end else if (branch_taken) begin
            next_pc = pc_plus1 + branch_offset;
        end
        next_in_range = (next_pc <= LAST_PC);
    end

    // PC, IR, halt flag and retire counter; reset wins, halt freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            InstrAddr     <= RESET_PC;
            instr_reg     <= 32'd0;
            halted        <= 1'b0;
            retired_count <= 32'd0;
        end else if (!halted) begin
            if (is_fetch) begin
                instr_reg <= ReadInstruction;
            end
            if (is_writeback) begin
                if (next_in_range) begin
                    InstrAddr <= next_pc;
                end else begin
                    halted <= 1'b1;
                end
                retired_count <= retired_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-register stage of the non-pipelined multi-cycle MIPS core.
- Drives the word address into instruction memory and latches the returned instruction during FETCH.
- Computes the next PC (sequential, branch, jump, jump-register) and commits it at the end of each instruction.
- Tracks retired instructions and flags a sticky halt when the next PC leaves instruction memory.

Parameters:
- RESET_PC, 0, word address loaded into PC on reset.
- MEM_DEPTH, 135, number of 32-bit words in instruction memory; valid PC range is 0..MEM_DEPTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- state  input  6  one-hot control state: 000001 IDLE, 000010 FETCH, 000100 DECODE, 001000 EXECUTE, 010000 MEM, 100000 WRITEBACK.
- ReadInstruction  input  32  instruction word from instruction memory.
- branch_taken  input  1  conditional branch resolved taken; sampled in WRITEBACK.
- jump  input  1  J/JAL; sampled in WRITEBACK.
- jump_reg  input  1  JR; sampled in WRITEBACK.
- rs_value  input  32  register rs contents; JR target.
- InstrAddr  output  32  current PC, word-indexed.
- instr_reg  output  32  latched instruction for decode/execute.
- pc_plus1  output  32  InstrAddr+1, combinational; link value for JAL.
- halted  output  1  sticky out-of-range halt flag.
- retired_count  output  32  number of instructions completed.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high and has priority over every other update.
- Reset values: InstrAddr=RESET_PC, instr_reg=0, halted=0, retired_count=0.
- Addressing: PC is a word index, not a byte address. Sequential increment is +1.
- IR capture: on a clk edge with state==FETCH and halted==0, instr_reg <= ReadInstruction. instr_reg is otherwise held.
- Next PC, combinational, fixed priority:
  1. jump_reg: rs_value.
  2. jump: {pc_plus1[31:26], instr_reg[25:0]}.
  3. branch_taken: pc_plus1 + sign-extend(instr_reg[15:0]), modulo 2^32.
  4. otherwise: pc_plus1.
- Commit: on a clk edge with state==WRITEBACK and halted==0:
  - If next PC <= MEM_DEPTH-1 (unsigned), InstrAddr <= next PC.
  - Otherwise InstrAddr is held and halted <= 1.
  - In both cases retired_count <= retired_count+1; the halting instruction is counted.
- Halted: no PC, IR or counter update until reset. InstrAddr keeps the last valid PC.
- Ignored inputs:
  - The branch, jump and jump_reg flags are ignored in every state except WRITEBACK.
  - state values that are not one-hot, or equal IDLE, DECODE, EXECUTE or MEM, cause no update.
- Counter and wrap: retired_count wraps 0xFFFFFFFF to 0. A branch offset that wraps below 0 produces a huge unsigned value, so it halts.
- Latency: a new PC is visible on InstrAddr the cycle after the WRITEBACK edge, ready for the next FETCH.
- Reset mid-instruction: in any state, reset restores all reset values on that edge. The partially executed instruction is not counted.

Test Plan:
- Reset, then 3 instructions each cycling FETCH..WRITEBACK with no flags -> InstrAddr 0→1→2→3, retired_count=3, instr_reg equals each ReadInstruction driven during its FETCH.
- PC=10, instr_reg[15:0]=0xFFFB, branch_taken=1 in WRITEBACK -> InstrAddr=6.
- PC=5, instr_reg[25:0]=40, jump=1 and branch_taken=1 together -> InstrAddr=40 (jump beats branch). Repeat with jump_reg=1, rs_value=7 -> InstrAddr=7.
- PC=20, jump_reg=1, rs_value=135 -> halted=1, InstrAddr stays 20, retired_count increments once. Further WRITEBACK cycles and FETCH with new ReadInstruction -> no change.
- Sequential run from PC=134 -> halted=1 at WRITEBACK, InstrAddr=134. Then reset -> InstrAddr=RESET_PC, halted=0, retired_count=0.
- Assert reset during EXECUTE with branch_taken=1, and separately drive state=000011 during a run -> reset values on that edge, and no update for the illegal state.
